// File: rtl/demux4_buffered.sv
// ---------------------------------------------------------------------------
// demux4_buffered : registered 1-to-4 demux, one-entry buffer per channel
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module demux4_buffered #(
  parameter int Size = 8
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [1:0]      select,
  input  logic [Size-1:0] data_i,
  input  logic            valid_i,
  output logic            ready_o,
  output logic [Size-1:0] data_o00,
  output logic [Size-1:0] data_o01,
  output logic [Size-1:0] data_o02,
  output logic [Size-1:0] data_o03,
  output logic            valid_o00,
  output logic            valid_o01,
  output logic            valid_o02,
  output logic            valid_o03,
  input  logic            ready_i00,
  input  logic            ready_i01,
  input  logic            ready_i02,
  input  logic            ready_i03
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } ch_state_e;

  logic [3:0]      ready_vec;
  logic [3:0]      valid_vec;
  logic [Size-1:0] data_vec [4];
  logic            in_xfer;

  assign ready_vec = {ready_i03, ready_i02, ready_i01, ready_i00};

  // A full channel can still accept when it drains in the same cycle.
  assign ready_o = !reset && (!valid_vec[select] || ready_vec[select]);
  assign in_xfer = valid_i && ready_o;

  genvar n;
  generate
    for (n = 0; n < 4; n++) begin : g_ch
      ch_state_e       state_q, state_d;
      logic [Size-1:0] data_q,  data_d;
      logic            load;

      assign load = in_xfer && (select == 2'(n));

      always_comb begin
        state_d = state_q;
        data_d  = data_q;
        if (load) begin
          state_d = FULL;
          data_d  = data_i;
        end else if (state_q == FULL && ready_vec[n]) begin
          state_d = EMPTY;
        end
      end

      always_ff @(posedge clock) begin
        if (reset) begin
          state_q <= EMPTY;
          data_q  <= '0;
        end else begin
          state_q <= state_d;
          data_q  <= data_d;
        end
      end

      assign valid_vec[n] = (state_q == FULL);
      assign data_vec[n]  = data_q;
    end
  endgenerate

  assign valid_o00 = valid_vec[0];
  assign valid_o01 = valid_vec[1];
  assign valid_o02 = valid_vec[2];
  assign valid_o03 = valid_vec[3];
  assign data_o00  = data_vec[0];
  assign data_o01  = data_vec[1];
  assign data_o02  = data_vec[2];
  assign data_o03  = data_vec[3];

endmodule

`default_nettype wire

// File: tb/tb_demux4_buffered.sv
// ---------------------------------------------------------------------------
// tb_demux4_buffered : directed vector bench for demux4_buffered
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_demux4_buffered;

  typedef struct {
    logic       rst;
    logic       vld;
    logic [1:0] sel;
    logic [7:0] din;
    logic [3:0] rdy;
    logic       exp_rdy;
    logic [3:0] exp_vld;
    logic [7:0] exp_d0;
    logic [7:0] exp_d1;
    logic [7:0] exp_d2;
    logic [7:0] exp_d3;
  } vec_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] select = 2'd0;
  logic [7:0] data_i = 8'h00;
  logic       valid_i = 1'b0;
  logic       ready_o;
  logic [7:0] data_o00, data_o01, data_o02, data_o03;
  logic       valid_o00, valid_o01, valid_o02, valid_o03;
  logic [3:0] rdy = 4'h0;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clock = ~clock;

  demux4_buffered #(.Size(8)) dut (
    .clock     (clock),
    .reset     (reset),
    .select    (select),
    .data_i    (data_i),
    .valid_i   (valid_i),
    .ready_o   (ready_o),
    .data_o00  (data_o00),
    .data_o01  (data_o01),
    .data_o02  (data_o02),
    .data_o03  (data_o03),
    .valid_o00 (valid_o00),
    .valid_o01 (valid_o01),
    .valid_o02 (valid_o02),
    .valid_o03 (valid_o03),
    .ready_i00 (rdy[0]),
    .ready_i01 (rdy[1]),
    .ready_i02 (rdy[2]),
    .ready_i03 (rdy[3])
  );

  function automatic vec_t mk(logic r, logic v, logic [1:0] s, logic [7:0] d,
                              logic [3:0] ri, logic er, logic [3:0] ev,
                              logic [7:0] e0, logic [7:0] e1,
                              logic [7:0] e2, logic [7:0] e3);
    vec_t t;
    t.rst = r; t.vld = v; t.sel = s; t.din = d; t.rdy = ri;
    t.exp_rdy = er; t.exp_vld = ev;
    t.exp_d0 = e0; t.exp_d1 = e1; t.exp_d2 = e2; t.exp_d3 = e3;
    return t;
  endfunction

  task automatic chk(input string name, input int idx,
                     input logic [7:0] act, input logic [7:0] exp);
    if (act !== exp) begin
      n_miss++;
      $display("FAIL vec%0d %s: got %h expected %h", idx, name, act, exp);
    end
  endtask

  // Drive on the falling edge, check ready_o before the rising edge and
  // the registered outputs just after it.
  task automatic run_vec(input int idx, input vec_t v);
    @(negedge clock);
    reset = v.rst; valid_i = v.vld; select = v.sel; data_i = v.din; rdy = v.rdy;
    #1;
    n_vec++;
    chk("ready_o", idx, {7'd0, ready_o}, {7'd0, v.exp_rdy});
    @(posedge clock);
    #1;
    chk("valid_o", idx, {4'd0, valid_o03, valid_o02, valid_o01, valid_o00},
        {4'd0, v.exp_vld});
    chk("data_o00", idx, data_o00, v.exp_d0);
    chk("data_o01", idx, data_o01, v.exp_d1);
    chk("data_o02", idx, data_o02, v.exp_d2);
    chk("data_o03", idx, data_o03, v.exp_d3);
  endtask

  vec_t tbl [13];

  initial begin
    //            rst vld sel din    rdy   erdy evld   d0     d1     d2     d3
    tbl[0]  = mk(1, 1, 2, 8'hFF, 4'hF, 0, 4'h0, 8'h00, 8'h00, 8'h00, 8'h00);
    tbl[1]  = mk(1, 1, 2, 8'hFF, 4'hF, 0, 4'h0, 8'h00, 8'h00, 8'h00, 8'h00);
    tbl[2]  = mk(0, 1, 2, 8'hA5, 4'hF, 1, 4'h4, 8'h00, 8'h00, 8'hA5, 8'h00);
    tbl[3]  = mk(0, 0, 0, 8'h00, 4'hF, 1, 4'h0, 8'h00, 8'h00, 8'hA5, 8'h00);
    tbl[4]  = mk(0, 1, 1, 8'h11, 4'hD, 1, 4'h2, 8'h00, 8'h11, 8'hA5, 8'h00);
    tbl[5]  = mk(0, 1, 1, 8'h22, 4'hD, 0, 4'h2, 8'h00, 8'h11, 8'hA5, 8'h00);
    tbl[6]  = mk(0, 1, 1, 8'h22, 4'hD, 0, 4'h2, 8'h00, 8'h11, 8'hA5, 8'h00);
    tbl[7]  = mk(0, 1, 1, 8'h22, 4'hF, 1, 4'h2, 8'h00, 8'h22, 8'hA5, 8'h00);
    tbl[8]  = mk(0, 0, 3, 8'h00, 4'hF, 1, 4'h0, 8'h00, 8'h22, 8'hA5, 8'h00);
    tbl[9]  = mk(0, 1, 0, 8'h5A, 4'hE, 1, 4'h1, 8'h5A, 8'h22, 8'hA5, 8'h00);
    tbl[10] = mk(0, 1, 3, 8'h33, 4'hE, 1, 4'h9, 8'h5A, 8'h22, 8'hA5, 8'h33);
    tbl[11] = mk(0, 1, 0, 8'h66, 4'hE, 0, 4'h1, 8'h5A, 8'h22, 8'hA5, 8'h33);
    tbl[12] = mk(0, 0, 0, 8'h00, 4'hF, 1, 4'h0, 8'h5A, 8'h22, 8'hA5, 8'h33);

    for (int i = 0; i < 13; i++) run_vec(i, tbl[i]);

    // Streaming: eight back-to-back words into channel 0.
    for (int k = 0; k < 8; k++)
      run_vec(100 + k, mk(0, 1, 0, 8'(k), 4'hF, 1, 4'h1,
                          8'(k), 8'h22, 8'hA5, 8'h33));
    run_vec(108, mk(0, 0, 0, 8'h00, 4'hF, 1, 4'h0, 8'h07, 8'h22, 8'hA5, 8'h33));

    // Reset mid-operation with channels 0 and 2 holding words.
    run_vec(200, mk(0, 1, 0, 8'hC0, 4'h0, 1, 4'h1, 8'hC0, 8'h22, 8'hA5, 8'h33));
    run_vec(201, mk(0, 1, 2, 8'hC2, 4'h0, 1, 4'h5, 8'hC0, 8'h22, 8'hC2, 8'h33));
    run_vec(202, mk(1, 1, 1, 8'hD1, 4'h0, 0, 4'h0, 8'h00, 8'h00, 8'h00, 8'h00));
    run_vec(203, mk(0, 1, 1, 8'hE1, 4'h0, 1, 4'h2, 8'h00, 8'hE1, 8'h00, 8'h00));
    run_vec(204, mk(0, 0, 1, 8'h00, 4'hF, 1, 4'h0, 8'h00, 8'hE1, 8'h00, 8'h00));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

`default_nettype wire
